// File: rtl/fetch_entry_arbiter_pkg.sv
// Shared types for the fetch entry arbiter.
//   fetch_entry_t : one decoded-fetch beat handed to the ID stage
//   arb_state_e   : arbiter FSM states (idle, burst locked to port 0 / port 1)
//   lock_state()  : maps a source index to its lock state
package fetch_entry_arbiter_pkg;

  localparam int unsigned NumSrc = 2;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StLock0,
    StLock1
  } arb_state_e;

  function automatic arb_state_e lock_state(input logic src);
    return src ? StLock1 : StLock0;
  endfunction

endpackage

// File: rtl/fetch_entry_arbiter_if.sv
// Handshake bundle between the two instruction sources, the arbiter and the ID stage.
//   src_entry_i / src_valid_i / src_last_i : per-source beat, valid and end-of-burst
//   src_ready_o                            : per-source acceptance
//   fetch_entry_o / fetch_valid_o          : muxed beat towards the ID stage
//   fetch_ready_i                          : ID stage acceptance
// Modports: slave = the arbiter, master = the surrounding sources and ID stage.
interface fetch_entry_arbiter_if;
  import fetch_entry_arbiter_pkg::*;

  fetch_entry_t [NumSrc-1:0] src_entry_i;
  logic [NumSrc-1:0]         src_valid_i;
  logic [NumSrc-1:0]         src_last_i;
  logic [NumSrc-1:0]         src_ready_o;
  fetch_entry_t              fetch_entry_o;
  logic                      fetch_valid_o;
  logic                      fetch_ready_i;

  modport slave (
    input  src_entry_i,
    input  src_valid_i,
    input  src_last_i,
    input  fetch_ready_i,
    output src_ready_o,
    output fetch_entry_o,
    output fetch_valid_o
  );

  modport master (
    output src_entry_i,
    output src_valid_i,
    output src_last_i,
    output fetch_ready_i,
    input  src_ready_o,
    input  fetch_entry_o,
    input  fetch_valid_o
  );

endinterface

// File: rtl/fetch_entry_arbiter_age_cnt.sv
// fetch_arb_age_cnt: saturating age counter for port 0 starvation protection.
// Only present when FETCH_ARB_AGE_GUARD_EN is defined.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : clear (port-0 beat fired or flush); wins over inc_i
//   inc_i        : port 0 waited this cycle
//   sat_o        : counter has reached MaxWait
`ifdef FETCH_ARB_AGE_GUARD_EN
module fetch_arb_age_cnt #(
  parameter int unsigned MaxWait = 8,
  parameter int unsigned CntW    = $clog2(MaxWait + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam logic [CntW-1:0] AgeMax = CntW'(MaxWait);

  logic [CntW-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (clr_i) begin
      age_d = '0;
    end else if (inc_i && (age_q != AgeMax)) begin
      age_d = age_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign sat_o = (age_q == AgeMax);

endmodule
`endif

// File: rtl/fetch_entry_arbiter.sv
// fetch_entry_arbiter: shares the single ID-stage decode slot between the frontend fetch
// queue (port 0) and the instruction injector (port 1). Port 1 has priority in idle; a
// beat with last=0 locks the arbiter onto its source until that source's last beat.
// Data path is combinational; only the arbitration state is registered.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush_i       : pipeline flush, abandons any burst in flight
//   bus           : fetch_entry_arbiter_if.slave handshake bundle
//   grant_src_o   : source of the current beat
//   locked_o      : burst lock held
// Optional feature: define FETCH_ARB_AGE_GUARD_EN to let port 0 win after MaxWait
// denied cycles while idle (a held lock is never broken by aging).
module fetch_entry_arbiter
  import fetch_entry_arbiter_pkg::*;
#(
  parameter int unsigned MaxWait = 8,
  parameter int unsigned CntW    = $clog2(MaxWait + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  fetch_entry_arbiter_if.slave  bus,
  output logic                  grant_src_o,
  output logic                  locked_o
);

  arb_state_e state_q;
  logic       locked_q;
  logic       grant;
  logic       kill;
  logic       fetch_valid;
  logic       fire;
  logic       age_sat;

  // Reset and flush both silence the handshake in the same cycle they are seen.
  assign kill = rst_i | flush_i;

`ifdef FETCH_ARB_AGE_GUARD_EN
  logic port0_fire;

  assign port0_fire = fire & ~grant;

  fetch_arb_age_cnt #(
    .MaxWait (MaxWait)
  ) u_age_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i | port0_fire),
    .inc_i (bus.src_valid_i[0] & ~port0_fire),
    .sat_o (age_sat)
  );
`else
  logic unused_cfg;

  assign age_sat    = 1'b0;
  assign unused_cfg = ^CntW'(MaxWait);
`endif

  always_comb begin
    grant = 1'b0;
    unique case (state_q)
      StLock0: grant = 1'b0;
      StLock1: grant = 1'b1;
      default: begin
        if (age_sat && bus.src_valid_i[0]) begin
          grant = 1'b0;
        end else if (bus.src_valid_i[1]) begin
          grant = 1'b1;
        end else begin
          grant = 1'b0;
        end
      end
    endcase
    if (rst_i) begin
      grant = 1'b0;
    end
  end

  assign fetch_valid = bus.src_valid_i[grant] & ~kill;
  assign fire        = fetch_valid & bus.fetch_ready_i;

  always_comb begin
    bus.src_ready_o = '0;
    if (!kill) begin
      bus.src_ready_o[grant] = bus.fetch_ready_i;
    end
  end

  assign bus.fetch_entry_o = bus.src_entry_i[grant];
  assign bus.fetch_valid_o = fetch_valid;
  assign grant_src_o       = grant;
  assign locked_o          = locked_q;

  // Release returns to idle only; the next winner is picked from idle a cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      locked_q <= 1'b0;
    end else if (flush_i) begin
      state_q  <= StIdle;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fire && !bus.src_last_i[grant]) begin
            state_q  <= lock_state(grant);
            locked_q <= 1'b1;
          end
        end
        StLock0, StLock1: begin
          if (fire && bus.src_last_i[grant]) begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_entry_arbiter.sv
module tb_fetch_entry_arbiter;
  import fetch_entry_arbiter_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic        last;
  } beat_t;

  typedef struct {
    logic        src;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic grant_src;
  logic locked;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  beat_t      src_q[2][$];
  exp_t       sb[$];
  logic [1:0] acc = 2'b00;

  fetch_entry_arbiter_if bus ();

  fetch_entry_arbiter #(
    .MaxWait (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .bus         (bus),
    .grant_src_o (grant_src),
    .locked_o    (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic fetch_entry_t mk_entry(input logic [31:0] instr);
    fetch_entry_t e;
    e.address     = instr ^ 32'hA5A5_0000;
    e.instruction = instr;
    return e;
  endfunction

  function automatic logic [31:0] mk_instr(input int t, input int p, input int i);
    return {8'(t), 8'(p), 16'(i)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (src_q[p].size() > 0) begin
        bus.src_valid_i[p] = 1'b1;
        bus.src_entry_i[p] = mk_entry(src_q[p][0].instr);
        bus.src_last_i[p]  = src_q[p][0].last;
      end else begin
        bus.src_valid_i[p] = 1'b0;
        bus.src_entry_i[p] = '0;
        bus.src_last_i[p]  = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int p, input logic [31:0] instr, input logic last);
    beat_t b;
    b.instr = instr;
    b.last  = last;
    src_q[p].push_back(b);
  endtask

  task automatic push_exp(input logic src, input logic [31:0] instr);
    exp_t e;
    e.src   = src;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((src_q[0].size() + src_q[1].size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(src_q[0].size() + src_q[1].size()), 64'd0);
    check_eq({tag, "_sb"}, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: every fired beat must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    acc[0] = bus.src_valid_i[0] & bus.src_ready_o[0];
    acc[1] = bus.src_valid_i[1] & bus.src_ready_o[1];
    if (bus.fetch_valid_o && bus.fetch_ready_i) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_beat", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_eq("beat_src", 64'(grant_src), 64'(e.src));
        check_eq("beat_entry", 64'(bus.fetch_entry_o), 64'(mk_entry(e.instr)));
      end
    end
  end

  // Source model: retire accepted beats, present the next one.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 2; p++) begin
      if (acc[p] && src_q[p].size() > 0) begin
        void'(src_q[p].pop_front());
      end
    end
    acc = 2'b00;
    drive();
  end

  initial begin
    int   c0;
    int   c1;
    logic g;
    logic exp_g[20];

    bus.fetch_ready_i = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_fetch_valid", 64'(bus.fetch_valid_o), 64'd0);
    check_eq("rst_src_ready", 64'(bus.src_ready_o), 64'd0);
    check_eq("rst_grant", 64'(grant_src), 64'd0);
    check_eq("rst_locked", 64'(locked), 64'd0);
    rst = 1'b0;

    // Single port-0 beats, port 1 idle.
    tick();
    for (int i = 0; i < 4; i++) begin
      push_src(0, mk_instr(6, 0, i), 1'b1);
      push_exp(1'b0, mk_instr(6, 0, i));
    end
    drive();
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check_eq("t6_grant", 64'(grant_src), 64'd0);
      check_eq("t6_locked", 64'(locked), 64'd0);
      check_eq("t6_valid", 64'(bus.fetch_valid_o), 64'd1);
      tick();
    end
    wait_drain("t6_drain", 20);

    // Both sources valid with single beats.
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 10; i++) begin
      push_src(1, mk_instr(1, 1, i), 1'b1);
      push_src(0, mk_instr(1, 0, i), 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
`ifdef FETCH_ARB_AGE_GUARD_EN
      g = (i == 8) ? 1'b0 : (i < 11);
`else
      g = (i < 10);
`endif
      exp_g[i] = g;
      if (g) begin
        push_exp(1'b1, mk_instr(1, 1, c1));
        c1++;
      end else begin
        push_exp(1'b0, mk_instr(1, 0, c0));
        c0++;
      end
    end
    drive();
    for (int i = 0; i < 20; i++) begin
      at_neg();
      check_eq("t1_grant", 64'(grant_src), 64'(exp_g[i]));
      check_eq("t1_src_ready", 64'(bus.src_ready_o), exp_g[i] ? 64'd2 : 64'd1);
      check_eq("t1_locked", 64'(locked), 64'd0);
      tick();
    end
    wait_drain("t1_drain", 20);

    // Port-0 burst; port 1 turns valid mid-burst.
    push_src(0, mk_instr(2, 0, 0), 1'b0);
    push_src(0, mk_instr(2, 0, 1), 1'b0);
    push_src(0, mk_instr(2, 0, 2), 1'b1);
    for (int i = 0; i < 3; i++) push_exp(1'b0, mk_instr(2, 0, i));
    drive();
    at_neg();
    check_eq("t2_b1_grant", 64'(grant_src), 64'd0);
    check_eq("t2_b1_locked", 64'(locked), 64'd0);
    tick();
    push_src(1, mk_instr(2, 1, 0), 1'b1);
    push_exp(1'b1, mk_instr(2, 1, 0));
    drive();
    at_neg();
    check_eq("t2_b2_locked", 64'(locked), 64'd1);
    check_eq("t2_b2_grant", 64'(grant_src), 64'd0);
    check_eq("t2_b2_src_ready", 64'(bus.src_ready_o), 64'd1);
    tick();
    at_neg();
    check_eq("t2_b3_locked", 64'(locked), 64'd1);
    check_eq("t2_b3_grant", 64'(grant_src), 64'd0);
    tick();
    at_neg();
    check_eq("t2_p1_locked", 64'(locked), 64'd0);
    check_eq("t2_p1_grant", 64'(grant_src), 64'd1);
    tick();
    wait_drain("t2_drain", 20);

    // Port-1 burst held off by the ID stage.
    push_src(1, mk_instr(3, 1, 0), 1'b0);
    push_src(1, mk_instr(3, 1, 1), 1'b1);
    push_exp(1'b1, mk_instr(3, 1, 0));
    push_exp(1'b1, mk_instr(3, 1, 1));
    drive();
    at_neg();
    check_eq("t3_b1_grant", 64'(grant_src), 64'd1);
    tick();
    bus.fetch_ready_i = 1'b0;
    push_src(0, mk_instr(3, 0, 0), 1'b1);
    push_exp(1'b0, mk_instr(3, 0, 0));
    drive();
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check_eq("t3_hold_locked", 64'(locked), 64'd1);
      check_eq("t3_hold_grant", 64'(grant_src), 64'd1);
      check_eq("t3_hold_valid", 64'(bus.fetch_valid_o), 64'd1);
      check_eq("t3_hold_entry", 64'(bus.fetch_entry_o), 64'(mk_entry(mk_instr(3, 1, 1))));
      check_eq("t3_hold_src_ready", 64'(bus.src_ready_o), 64'd0);
      tick();
    end
    bus.fetch_ready_i = 1'b1;
    at_neg();
    check_eq("t3_last_grant", 64'(grant_src), 64'd1);
    tick();
    at_neg();
    check_eq("t3_after_locked", 64'(locked), 64'd0);
    check_eq("t3_after_grant", 64'(grant_src), 64'd0);
    tick();
    wait_drain("t3_drain", 20);

    // Flush in the middle of a port-0 burst.
    push_src(0, mk_instr(4, 0, 0), 1'b0);
    push_src(0, mk_instr(4, 0, 1), 1'b0);
    push_src(0, mk_instr(4, 0, 2), 1'b1);
    push_exp(1'b0, mk_instr(4, 0, 0));
    drive();
    at_neg();
    check_eq("t4_b1_grant", 64'(grant_src), 64'd0);
    tick();
    flush = 1'b1;
    at_neg();
    check_eq("t4_flush_valid", 64'(bus.fetch_valid_o), 64'd0);
    check_eq("t4_flush_src_ready", 64'(bus.src_ready_o), 64'd0);
    check_eq("t4_flush_locked", 64'(locked), 64'd1);
    tick();
    flush = 1'b0;
    src_q[0].delete();
    drive();
    at_neg();
    check_eq("t4_post_locked", 64'(locked), 64'd0);
    check_eq("t4_post_valid", 64'(bus.fetch_valid_o), 64'd0);
    tick();
    push_src(0, mk_instr(4, 0, 9), 1'b1);
    push_exp(1'b0, mk_instr(4, 0, 9));
    drive();
    at_neg();
    check_eq("t4_restart_valid", 64'(bus.fetch_valid_o), 64'd1);
    check_eq("t4_restart_locked", 64'(locked), 64'd0);
    tick();
    wait_drain("t4_drain", 20);

    // Reset pulse during a port-1 lock with both sources valid.
    push_src(1, mk_instr(5, 1, 0), 1'b0);
    push_src(1, mk_instr(5, 1, 1), 1'b0);
    push_src(1, mk_instr(5, 1, 2), 1'b1);
    push_src(0, mk_instr(5, 0, 0), 1'b1);
    push_exp(1'b1, mk_instr(5, 1, 0));
    drive();
    at_neg();
    check_eq("t5_b1_grant", 64'(grant_src), 64'd1);
    tick();
    check_eq("t5_pre_locked", 64'(locked), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", 64'(bus.fetch_valid_o), 64'd0);
    check_eq("t5_rst_src_ready", 64'(bus.src_ready_o), 64'd0);
    check_eq("t5_rst_grant", 64'(grant_src), 64'd0);
    check_eq("t5_rst_locked", 64'(locked), 64'd0);
    at_neg();
    tick();
    rst = 1'b0;
    src_q[1].delete();
    push_src(1, mk_instr(5, 1, 7), 1'b1);
    push_exp(1'b1, mk_instr(5, 1, 7));
    push_exp(1'b0, mk_instr(5, 0, 0));
    drive();
    at_neg();
    check_eq("t5_post_grant", 64'(grant_src), 64'd1);
    check_eq("t5_post_locked", 64'(locked), 64'd0);
    tick();
    wait_drain("t5_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
